sensor_alarm_ctrl: RTL and testbench

Sequential alarm controller that sits downstream of the combinational sensor error detector and consumes its single-bit `error` flag. It debounces the flag, raises a latched `alarm` toward the operator/host, waits for an acknowledge handshake, and suppresses re-alarming on the same persistent fault. It also keeps a saturating count of qualified alarm events.

---
 rtl/sensor_alarm_ctrl.sv | 131 +++++++++++++
 tb/tb_sensor_alarm_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sensor_alarm_ctrl.sv
// Debounced, acknowledge-driven alarm controller for the sensor error flag.
// Optional macro SENSOR_ALARM_SYNC_EN adds a 2-flop synchronizer on `error`.
module sensor_alarm_ctrl #(
    parameter int DEBOUNCE  = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 error,
    input  logic                 ack,
    output logic                 alarm,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] event_count
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0]        DEB_LAST = DW'(DEBOUNCE - 1);
    localparam logic [DW-1:0]        DEB_ONE  = DW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        QUALIFY,
        ALARM,
        HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [DW-1:0]        deb_q, deb_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 alarm_q, alarm_d;
    logic                 busy_q, busy_d;
    logic                 err_s;

`ifdef SENSOR_ALARM_SYNC_EN
    logic [1:0] sync_q, sync_d;

    assign sync_d = {sync_q[0], error};
    assign err_s  = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end
`else
    assign err_s = error;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            deb_q   <= '0;
            cnt_q   <= '0;
            alarm_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
            busy_q  <= busy_d;
        end
    end

    // The debounce counter is cleared on every path that lands in IDLE.
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        case (state_q)
            IDLE: begin
                deb_d = '0;
                if (err_s) begin
                    if (DEBOUNCE == 1) begin
                        state_d = ALARM;
                    end else begin
                        state_d = QUALIFY;
                        deb_d   = DEB_ONE;
                    end
                end
            end
            QUALIFY: begin
                if (!err_s) begin
                    state_d = IDLE;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = ALARM;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            ALARM: begin
                if (ack) begin
                    if (err_s) begin
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                        deb_d   = '0;
                    end
                end
            end
            HOLD: begin
                if (!err_s) begin
                    state_d = IDLE;
                    deb_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                deb_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave as plain flops.
    always_comb begin
        alarm_d = (state_d == ALARM);
        busy_d  = (state_d != IDLE);
        cnt_d   = cnt_q;
        if ((state_d == ALARM) && (state_q != ALARM) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign alarm       = alarm_q;
    assign busy        = busy_q;
    assign event_count = cnt_q;

endmodule

// File: tb/tb_sensor_alarm_ctrl.sv
// Self-checking bench: two instances (DEBOUNCE=4/CNT_WIDTH=2 and DEBOUNCE=1/CNT_WIDTH=8)
// driven by shared stimulus and compared against a run-length reference model.
module tb_sensor_alarm_ctrl;

    logic       clk;
    logic       rst;
    logic       error;
    logic       ack;
    logic       alarm4, busy4;
    logic [1:0] cnt4;
    logic       alarm1, busy1;
    logic [7:0] cnt1;

    int compared;
    int mismatched;

    // Reference model state, index 0 = DEBOUNCE 4 instance, index 1 = DEBOUNCE 1 instance.
    int dval[2];
    int cmax[2];
    int mRun[2];
    int mCnt[2];
    bit mAlarm[2];
    bit mHold[2];
    bit s1, s2;

    sensor_alarm_ctrl #(.DEBOUNCE(4), .CNT_WIDTH(2)) dut4 (
        .clk(clk), .rst(rst), .error(error), .ack(ack),
        .alarm(alarm4), .busy(busy4), .event_count(cnt4)
    );

    sensor_alarm_ctrl #(.DEBOUNCE(1), .CNT_WIDTH(8)) dut1 (
        .clk(clk), .rst(rst), .error(error), .ack(ack),
        .alarm(alarm1), .busy(busy1), .event_count(cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mRun[i]   = 0;
            mCnt[i]   = 0;
            mAlarm[i] = 1'b0;
            mHold[i]  = 1'b0;
        end
        s1 = 1'b0;
        s2 = 1'b0;
    endtask

    // One rising edge worth of behaviour: count consecutive high samples,
    // fire once per qualified run, and suppress until the fault clears.
    task automatic modelEdge(input bit e, input bit a);
        bit es;
`ifdef SENSOR_ALARM_SYNC_EN
        es = s2;
        s2 = s1;
        s1 = e;
`else
        es = e;
`endif
        for (int i = 0; i < 2; i++) begin
            if (mAlarm[i]) begin
                if (a) begin
                    mAlarm[i] = 1'b0;
                    mHold[i]  = es;
                end
            end else if (mHold[i]) begin
                if (!es) mHold[i] = 1'b0;
            end else if (es) begin
                mRun[i]++;
                if (mRun[i] >= dval[i]) begin
                    mAlarm[i] = 1'b1;
                    mRun[i]   = 0;
                    if (mCnt[i] < cmax[i]) mCnt[i]++;
                end
            end else begin
                mRun[i] = 0;
            end
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".alarm4"}, 32'(alarm4), 32'(mAlarm[0]));
        checkOutput({tag, ".busy4"},  32'(busy4),  32'(mAlarm[0] | mHold[0] | (mRun[0] > 0)));
        checkOutput({tag, ".cnt4"},   32'(cnt4),   32'(mCnt[0]));
        checkOutput({tag, ".alarm1"}, 32'(alarm1), 32'(mAlarm[1]));
        checkOutput({tag, ".busy1"},  32'(busy1),  32'(mAlarm[1] | mHold[1] | (mRun[1] > 0)));
        checkOutput({tag, ".cnt1"},   32'(cnt1),   32'(mCnt[1]));
    endtask

    task automatic applyStimulus(input string tag, input bit e, input bit a);
        error = e;
        ack   = a;
        @(posedge clk);
        modelEdge(e, a);
        #2;
        checkAll(tag);
    endtask

    initial begin
        bit e;
        bit a;
        compared   = 0;
        mismatched = 0;
        dval[0] = 4;  cmax[0] = 3;
        dval[1] = 1;  cmax[1] = 255;
        rst   = 1'b1;
        error = 1'b0;
        ack   = 1'b0;
        modelReset();

        repeat (2) @(posedge clk);
        #2;
        checkAll("reset");
        rst = 1'b0;

        // Three-cycle glitch never qualifies the DEBOUNCE=4 instance.
        for (int i = 0; i < 3; i++) applyStimulus($sformatf("glitch%0d", i), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus($sformatf("glitchlow%0d", i), 1'b0, 1'b0);

        // Persistent fault: alarm, ack while still high, hold, then release.
        for (int i = 0; i < 6; i++) applyStimulus($sformatf("hold_hi%0d", i), 1'b1, 1'b0);
        applyStimulus("hold_ack", 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus($sformatf("hold_stay%0d", i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus($sformatf("hold_drop%0d", i), 1'b0, 1'b0);

        // Single-cycle error, then ack coinciding with error low.
        applyStimulus("single_hi", 1'b1, 1'b0);
        applyStimulus("single_ack", 1'b0, 1'b1);
        applyStimulus("single_idle", 1'b0, 1'b0);
        applyStimulus("idle_ack", 1'b0, 1'b1);

        // Five acknowledged alarms drive the 2-bit counter into saturation.
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) applyStimulus($sformatf("sat%0d_hi%0d", k, i), 1'b1, 1'b0);
            applyStimulus($sformatf("sat%0d_ack", k), 1'b0, 1'b1);
            applyStimulus($sformatf("sat%0d_idle", k), 1'b0, 1'b0);
        end

        // Fresh run up to a second live alarm, then asynchronous reset mid-cycle.
        @(negedge clk);
        rst = 1'b1;
        #1;
        modelReset();
        checkAll("rst_pulse");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) applyStimulus($sformatf("pre%0d_hi%0d", k, i), 1'b1, 1'b0);
            if (k == 0) begin
                applyStimulus("pre_ack", 1'b0, 1'b1);
                applyStimulus("pre_idle", 1'b0, 1'b0);
            end
        end
        #1;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll("async_rst");
        @(posedge clk);
        #2;
        error = 1'b0;
        rst   = 1'b0;

        // Randomized phase: error tends to persist, ack arrives sporadically.
        e = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) e = ~e;
            a = ($urandom_range(4) == 0);
            applyStimulus($sformatf("rand%0d", i), e, a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
